// File: rtl/mul_pkg.sv
// mul_pkg: definitions shared by the shift-add multiplier scheduler.
//   state_t     : scheduler states (IDLE, RUN)
//   REQ0 / REQ1 : requester id values carried on done_id
//   DEF_WIDTH   : default operand width
package mul_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mul_sched_if.sv
// mul_sched_if: bundle between the two operand sources and the multiplier
// scheduler.
//   req0/a0/b0, req1/a1/b1 : requests and operands (source -> scheduler)
//   gnt0/gnt1              : one-cycle operand-capture pulses
//   busy                   : multiply in progress
//   done/done_id/op        : result pulse, owning requester, product
// master = operand source side, slave = scheduler side.
interface mul_sched_if
   import mul_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic               req0;
   logic [WIDTH-1:0]   a0;
   logic [WIDTH-1:0]   b0;
   logic               gnt0;
   logic               req1;
   logic [WIDTH-1:0]   a1;
   logic [WIDTH-1:0]   b1;
   logic               gnt1;
   logic               busy;
   logic               done;
   logic               done_id;
   logic [2*WIDTH-1:0] op;

   modport master (
      output req0, a0, b0, req1, a1, b1,
      input  gnt0, gnt1, busy, done, done_id, op
   );

   modport slave (
      input  req0, a0, b0, req1, a1, b1,
      output gnt0, gnt1, busy, done, done_id, op
   );

endinterface

// File: rtl/mul_sched_dp.sv
// mul_sched_dp: shift-add multiplier datapath (WIDTH >= 2).
//   clk       : clock
//   ld        : load A <- a_in, P <- {0, b_in}, clear step counter
//   step      : one add/shift step
//   a_in/b_in : winning requester's operands
//   p_next    : value P takes on a step edge (the product on the last step)
//   last_step : current step is the final one (cnt == WIDTH-1)
module mul_sched_dp
   import mul_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               ld,
   input  logic               step,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic [2*WIDTH-1:0] p_next,
   output logic               last_step
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0]   a_q;
   logic [2*WIDTH-1:0] p_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH:0]     sum;

   // Keeping the adder carry as the new top bit means the upper half never
   // overflows; after WIDTH steps P holds the full 2*WIDTH-bit product.
   assign sum       = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? a_q : '0)};
   assign p_next    = {sum, p_q[WIDTH-1:1]};
   assign last_step = (cnt_q == CW'(WIDTH - 1));

   // NOTE: no reset on the datapath registers; every job starts with ld, and
   // the controller ignores them outside RUN.
   always_ff @(posedge clk) begin
      if (ld) begin
         a_q   <= a_in;
         p_q   <= {{WIDTH{1'b0}}, b_in};
         cnt_q <= '0;
      end else if (step) begin
         p_q   <= p_next;
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler sharing one shift-add multiplier between
// two requesters.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : mul_sched_if.slave (requests/operands in; grants, busy, done,
//         done_id, op out, all registered)
module mul_sched
   import mul_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic       clk,
   input  logic       rst,
   mul_sched_if.slave bus
);

   state_t             state;
   logic               last_id;
   logic               owner;
   logic               any_req;
   logic               win;
   logic [WIDTH-1:0]   a_win;
   logic [WIDTH-1:0]   b_win;
   logic               ld;
   logic               step;
   logic [2*WIDTH-1:0] p_next;
   logic               last_step;

   assign any_req = bus.req0 | bus.req1;
   // Under contention the requester not granted last wins.
   assign win     = (bus.req0 & bus.req1) ? ~last_id : bus.req1;
   assign a_win   = win ? bus.a1 : bus.a0;
   assign b_win   = win ? bus.b1 : bus.b0;
   assign ld      = (state == IDLE) & any_req;
   assign step    = (state == RUN);

   mul_sched_dp #(.WIDTH(WIDTH)) u_dp (
      .clk       (clk),
      .ld        (ld),
      .step      (step),
      .a_in      (a_win),
      .b_in      (b_win),
      .p_next    (p_next),
      .last_step (last_step)
   );

   // NOTE: all state and output registers use non-blocking assignments so
   // every read in this block sees the pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_id     <= REQ1;   // favour requester 0 after reset
         owner       <= REQ0;
         bus.gnt0    <= 1'b0;
         bus.gnt1    <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.done_id <= 1'b0;
         bus.op      <= '0;
      end else begin
         bus.gnt0 <= 1'b0;
         bus.gnt1 <= 1'b0;
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state    <= RUN;
                  owner    <= win;
                  last_id  <= win;
                  bus.gnt0 <= (win == REQ0);
                  bus.gnt1 <= (win == REQ1);
                  bus.busy <= 1'b1;
               end
            end
            RUN: begin
               if (last_step) begin
                  state       <= IDLE;
                  bus.busy    <= 1'b0;
                  bus.done    <= 1'b1;
                  bus.done_id <= owner;
                  bus.op      <= p_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: self-checking bench for mul_sched. Two requester agents
// serve job queues; a transaction-level model predicts every output each
// cycle, and directed tests pin products, ids and latencies to literals.
module tb_mul_sched;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } job_t;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   bit   chk_en   = 0;

   job_t q0[$];
   job_t q1[$];

   mul_sched_if #(.WIDTH(W)) bus ();

   mul_sched #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Requester agents: present the head job and hold it until its grant.
   always @(negedge clk) begin
      if (bus.gnt0 && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
         bus.req0 = 1'b1; bus.a0 = q0[0].a; bus.b0 = q0[0].b;
      end else begin
         bus.req0 = 1'b0;
      end
      if (bus.gnt1 && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
         bus.req1 = 1'b1; bus.a1 = q1[0].a; bus.b1 = q1[0].b;
      end else begin
         bus.req1 = 1'b0;
      end
      if (bus.done) done_cnt++;
   end

   // Transaction-level model: a job occupies the multiplier for W edges after
   // its grant and then reports a*b once.
   logic         exp_gnt0, exp_gnt1, exp_busy, exp_done, exp_done_id;
   logic [2*W-1:0] exp_op, m_prod;
   logic         m_last, m_owner;
   int           remain;

   always @(posedge clk) begin
      exp_gnt0 = 1'b0;
      exp_gnt1 = 1'b0;
      exp_done = 1'b0;
      if (rst) begin
         exp_busy = 1'b0; exp_done_id = 1'b0; exp_op = '0;
         m_last = 1'b1; remain = 0;
      end else if (remain > 0) begin
         remain--;
         if (remain == 0) begin
            exp_done = 1'b1; exp_busy = 1'b0;
            exp_op = m_prod; exp_done_id = m_owner;
         end
      end else if (bus.req0 || bus.req1) begin
         m_owner = (bus.req0 && bus.req1) ? !m_last : bus.req1;
         m_prod  = m_owner ? (2*W)'(int'(bus.a1) * int'(bus.b1))
                           : (2*W)'(int'(bus.a0) * int'(bus.b0));
         m_last  = m_owner;
         remain  = W;
         exp_busy = 1'b1;
         if (m_owner) exp_gnt1 = 1'b1; else exp_gnt0 = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("gnt0", bus.gnt0, exp_gnt0);
         check("gnt1", bus.gnt1, exp_gnt1);
         check("busy", bus.busy, exp_busy);
         check("done", bus.done, exp_done);
         check("done_id", bus.done_id, exp_done_id);
         check("op", bus.op, exp_op);
         check("single_grant", bus.gnt0 & bus.gnt1, 0);
      end
   end

   task automatic wait_done(output logic [2*W-1:0] o, output logic id, output int at);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 200);
      if (!bus.done) check("done_timeout", 0, 1);
      o  = bus.op;
      id = bus.done_id;
      at = cyc;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push(input bit id, input int a, input int b);
      job_t j;
      j.a = W'(a);
      j.b = W'(b);
      if (id) q1.push_back(j); else q0.push_back(j);
   endtask

   logic [2*W-1:0] o;
   logic           id;
   int             t0, at, at_prev;
   int             zt[3][3] = '{'{0, 13, 0}, '{1, 11, 11}, '{15, 0, 0}};

   initial begin
      rst = 1'b1;
      bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
      bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_op", bus.op, 0);
      check("reset_busy", bus.busy, 0);

      // Single request 15x15; latency counts the request edge itself.
      @(posedge clk); #1; t0 = cyc; push(0, 15, 15);
      wait_done(o, id, at);
      check("single_op", o, 225);
      check("single_id", id, 0);
      check("single_latency", at - t0, W + 1);

      // First contention after reset: requester 0 first.
      do_reset();
      @(posedge clk); #1; push(0, 3, 5); push(1, 7, 6);
      wait_done(o, id, at_prev);
      check("cont1_first_op", o, 15);
      check("cont1_first_id", id, 0);
      wait_done(o, id, at);
      check("cont1_second_op", o, 42);
      check("cont1_second_id", id, 1);
      check("cont1_gap", at - at_prev, W + 1);

      // Requester 0 served alone, so the next contention favours requester 1.
      @(posedge clk); #1; push(0, 2, 3);
      wait_done(o, id, at);
      check("solo_op", o, 6);
      @(posedge clk); #1; push(0, 4, 4); push(1, 5, 5);
      wait_done(o, id, at);
      check("cont2_first_op", o, 25);
      check("cont2_first_id", id, 1);
      wait_done(o, id, at);
      check("cont2_second_op", o, 16);
      check("cont2_second_id", id, 0);

      // Back-to-back on requester 1.
      @(posedge clk); #1; push(1, 9, 4); push(1, 2, 8);
      wait_done(o, id, at_prev);
      check("b2b_first_op", o, 36);
      wait_done(o, id, at);
      check("b2b_second_op", o, 16);
      check("b2b_second_id", id, 1);
      check("b2b_gap", at - at_prev, W + 1);

      // Zeros and identity.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1; t0 = cyc; push(0, zt[i][0], zt[i][1]);
         wait_done(o, id, at);
         check($sformatf("zero_op_%0d", i), o, zt[i][2]);
         check($sformatf("zero_latency_%0d", i), at - t0, W + 1);
      end

      // Reset during step 2 of 12x12 aborts the job.
      @(posedge clk); #1; push(1, 12, 12);
      begin
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!bus.gnt1 && n < 20);
         check("abort_grant_seen", bus.gnt1, 1);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_gnt0", bus.gnt0, 0);
      check("abort_gnt1", bus.gnt1, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_done_id", bus.done_id, 0);
      check("abort_op", bus.op, 0);
      at_prev = done_cnt;
      repeat (8) @(negedge clk);
      check("abort_no_done", done_cnt - at_prev, 0);
      @(posedge clk); #1; push(1, 5, 7);
      wait_done(o, id, at);
      check("after_abort_op", o, 35);
      check("after_abort_id", id, 1);

      // Exhaustive sweep, alternating requesters, all queued at once.
      @(posedge clk); #1;
      at_prev = done_cnt;
      for (int i = 0; i < 256; i++) push(i[0], i / 16, i % 16);
      begin
         int n = 0;
         while ((q0.size() > 0 || q1.size() > 0 || bus.busy || done_cnt - at_prev < 256)
                && n < 256 * (W + 1) + 100) begin
            @(negedge clk);
            n++;
         end
      end
      repeat (2) @(negedge clk);
      check("sweep_done_count", done_cnt - at_prev, 256);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
